alu_carry_combiner: RTL

// - Consumer end of the 4-bit ALU slice PLA. Takes that slice's per-bit half-sum (h) and generate (g) nibbles, one nibble per beat, LSB nibble first.
// - Resolves the ripple carry across beats and assembles the full-width sum.
// - Reports carry-out, zero and signed overflow.
// - Sits between the slice array's sequencer and the writeback register.

---
 rtl/alu_carry_combiner.sv | 111 +++++++++++
 1 files changed

// File: rtl/alu_carry_combiner.sv
// Carry resolver for the 4-bit ALU slice: accepts h/g nibbles LSB first,
// ripples the carry across beats and presents sum, carry-out, zero and overflow.
module alu_carry_combiner #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_h,
    input  logic [3:0]           in_g,
    input  logic                 in_cin,
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [4*NIBBLES-1:0] out_sum,
    output logic                 out_cout,
    output logic                 out_zero,
    output logic                 out_ovf
);

    localparam int unsigned W  = 4 * NIBBLES;
    localparam int unsigned CW = $clog2(NIBBLES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic            carry;
    logic [W-1:0]    acc;

    logic [4:0]      c;
    logic [3:0]      s;
    logic [W-1:0]    acc_next;
    logic            last_beat;

    always_comb begin
        c        = '0;
        s        = '0;
        c[0]     = (cnt == '0) ? in_cin : carry;
        for (int unsigned i = 0; i < 4; i++) begin
            s[i]   = in_h[i] ^ c[i];
            c[i+1] = in_g[i] | (in_h[i] & c[i]);
        end
        acc_next = acc;
        acc_next[4*int'(cnt) +: 4] = s;
        last_beat = (cnt == CW'(NIBBLES - 1));
    end

    assign out_zero = (out_sum == '0);

    // Partial sums live in acc so out_* only change when a word completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            carry     <= 1'b0;
            acc       <= '0;
            out_sum   <= '0;
            out_cout  <= 1'b0;
            out_ovf   <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (abort) begin
                        state <= IDLE;
                        cnt   <= '0;
                        carry <= 1'b0;
                    end else if (in_valid) begin
                        acc <= acc_next;
                        if (last_beat) begin
                            out_sum   <= acc_next;
                            out_cout  <= c[4];
                            out_ovf   <= c[4] ^ c[3];
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            cnt       <= '0;
                            carry     <= 1'b0;
                            state     <= DONE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            carry <= c[4];
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    carry     <= 1'b0;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
